// File: rtl/fwrisc_exec_ctrl.sv
// rtl/fwrisc_exec_ctrl.sv - fwrisc execute controller: sequencing, PC ownership, trap entry
// Optional alignment traps are enabled by defining FWRISC_EXEC_MISALIGN_TRAP_EN.
module fwrisc_exec_ctrl #(
    parameter int              XLEN              = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR      = 32'h8000_0000,
    parameter int              ENABLE_COMPRESSED = 1,
    parameter int              CAUSE_W           = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            decode_valid,
    input  logic            instr_c,
    input  logic [4:0]      op_type,
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] op_c,
    input  logic [5:0]      rd,
    input  logic [XLEN-1:0] mtvec,
    input  logic            irq,
    input  logic            mie,
    output logic            instr_complete,
    output logic [XLEN-1:0] pc,
    output logic            pc_seq,
    output logic [5:0]      rd_waddr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            rd_wen,
    output logic            mds_in_valid,
    input  logic            mds_out_valid,
    input  logic [XLEN-1:0] mds_out,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_ack_valid,
    input  logic [XLEN-1:0] mem_ack_data
);
    localparam logic [4:0] OP_TYPE_ARITH  = 5'd0;
    localparam logic [4:0] OP_TYPE_BRANCH = 5'd1;
    localparam logic [4:0] OP_TYPE_JUMP   = 5'd2;
    localparam logic [4:0] OP_TYPE_CSR    = 5'd3;
    localparam logic [4:0] OP_TYPE_MDS    = 5'd4;
    localparam logic [4:0] OP_TYPE_LDST   = 5'd5;
    localparam logic [4:0] OP_TYPE_SYSTEM = 5'd6;
    localparam logic [5:0] CSR_MEPC   = 6'h21;
    localparam logic [5:0] CSR_MCAUSE = 6'h22;
    localparam logic [5:0] CSR_MTVAL  = 6'h23;

    typedef enum logic [3:0] {
        EXECUTE, BRANCH_TAKEN, JUMP, CSR, MDS_WAIT, LDST_WAIT, EXC_EPC, EXC_TVAL, EXC_CAUSE
    } state_e;

    state_e               state_q;
    logic [XLEN-1:0]      pc_q, epc_q, tval_q, mem_req_addr_q;
    logic                 pc_seq_q, ic_q, mem_req_valid_q, mds_in_valid_q, flag_q;
    logic [CAUSE_W-1:0]   cause_q;

    logic [XLEN-1:0] pc_next_seq, alu_res, csr_res, ldst_addr, br_target, jmp_target;
    logic [XLEN-1:0] trap_base, trap_target, mcause_val;
    logic            br_taken, accept, is_store;

    assign pc_next_seq = pc_q + (((ENABLE_COMPRESSED != 0) && instr_c) ? XLEN'(2) : XLEN'(4));
    assign ldst_addr   = op_a + op_c;
    assign br_target   = (pc_q + op_c) & ~XLEN'(1);
    assign jmp_target  = (op_a + op_c) & ~XLEN'(1);
    assign is_store    = op[3];
    assign accept      = (state_q == EXECUTE) && decode_valid && !ic_q;
    assign trap_base   = {mtvec[XLEN-1:2], 2'b00};
    // Only interrupts are vectored; synchronous exceptions always land on the base.
    assign trap_target = (mtvec[1:0] == 2'b01 && flag_q) ? trap_base + XLEN'({cause_q, 2'b00}) : trap_base;
    assign mcause_val  = {flag_q, (XLEN-1)'(cause_q)};

    always_comb begin
        alu_res = op_a + op_b;
        case (op)
            6'd1:    alu_res = op_a - op_b;
            6'd2:    alu_res = op_a & op_b;
            6'd3:    alu_res = op_a | op_b;
            6'd4:    alu_res = op_a ^ op_b;
            6'd5:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
            6'd6:    alu_res = XLEN'(op_a < op_b);
            6'd7:    alu_res = op_b;
            default: alu_res = op_a + op_b;
        endcase
        case (op)
            6'd1:    csr_res = op_b | op_a;
            6'd2:    csr_res = op_b & ~op_a;
            default: csr_res = op_a;
        endcase
        case (op)
            6'd1:    br_taken = (op_a != op_b);
            6'd2:    br_taken = ($signed(op_a) < $signed(op_b));
            6'd3:    br_taken = ($signed(op_a) >= $signed(op_b));
            6'd4:    br_taken = (op_a < op_b);
            6'd5:    br_taken = (op_a >= op_b);
            default: br_taken = (op_a == op_b);
        endcase
    end

`ifdef FWRISC_EXEC_MISALIGN_TRAP_EN
    logic ldst_misalign, br_misalign, jmp_misalign;
    assign ldst_misalign = (op[1:0] == 2'b01 && ldst_addr[0]) || (op[1:0] == 2'b10 && ldst_addr[1:0] != 2'b00);
    assign br_misalign   = (ENABLE_COMPRESSED == 0) && br_target[1];
    assign jmp_misalign  = (ENABLE_COMPRESSED == 0) && jmp_target[1];
`endif

    always_comb begin
        rd_wen   = 1'b0;
        rd_waddr = rd;
        rd_wdata = alu_res;
        case (state_q)
            EXECUTE: if (accept && !(irq && mie)) begin
                case (op_type)
                    OP_TYPE_ARITH: rd_wen = 1'b1;
                    OP_TYPE_JUMP: begin rd_wen = 1'b1; rd_wdata = pc_next_seq; end
                    OP_TYPE_CSR: begin rd_wen = 1'b1; rd_waddr = op_c[5:0]; rd_wdata = csr_res; end
                    default: rd_wen = 1'b0;
                endcase
            end
            CSR:       begin rd_wen = 1'b1; rd_wdata = op_b; end
            MDS_WAIT:  begin rd_wen = mds_out_valid; rd_wdata = mds_out; end
            LDST_WAIT: begin rd_wen = mem_ack_valid && !is_store; rd_wdata = mem_ack_data; end
            EXC_EPC:   begin rd_wen = 1'b1; rd_waddr = CSR_MEPC; rd_wdata = epc_q; end
            EXC_TVAL:  begin rd_wen = 1'b1; rd_waddr = CSR_MTVAL; rd_wdata = tval_q; end
            EXC_CAUSE: begin rd_wen = 1'b1; rd_waddr = CSR_MCAUSE; rd_wdata = mcause_val; end
            default:   rd_wen = 1'b0;
        endcase
        if (reset) rd_wen = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= EXECUTE;
            pc_q            <= RESET_VECTOR;
            pc_seq_q        <= 1'b1;
            ic_q            <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mds_in_valid_q  <= 1'b0;
            cause_q         <= '0;
            flag_q          <= 1'b0;
            epc_q           <= '0;
            tval_q          <= '0;
        end else begin
            ic_q           <= 1'b0;
            mds_in_valid_q <= 1'b0;
            case (state_q)
                EXECUTE: if (accept) begin
                    if (irq && mie) begin
                        epc_q <= pc_q; tval_q <= '0; flag_q <= 1'b1; cause_q <= CAUSE_W'(11);
                        state_q <= EXC_EPC;
                    end else begin
                        case (op_type)
                            OP_TYPE_BRANCH: begin
                                if (br_taken) state_q <= BRANCH_TAKEN;
                                else begin pc_q <= pc_next_seq; pc_seq_q <= 1'b1; ic_q <= 1'b1; end
                            end
                            OP_TYPE_JUMP: state_q <= JUMP;
                            OP_TYPE_CSR:  state_q <= CSR;
                            OP_TYPE_MDS:  begin mds_in_valid_q <= 1'b1; state_q <= MDS_WAIT; end
                            OP_TYPE_LDST: begin
`ifdef FWRISC_EXEC_MISALIGN_TRAP_EN
                                if (ldst_misalign) begin
                                    epc_q <= pc_q; tval_q <= ldst_addr; flag_q <= 1'b0;
                                    cause_q <= is_store ? CAUSE_W'(6) : CAUSE_W'(4);
                                    state_q <= EXC_EPC;
                                end else
`endif
                                begin
                                    mem_req_valid_q <= 1'b1; mem_req_addr_q <= ldst_addr;
                                    state_q <= LDST_WAIT;
                                end
                            end
                            OP_TYPE_SYSTEM: begin
                                case (op)
                                    6'd0: begin pc_q <= op_a; pc_seq_q <= 1'b0; ic_q <= 1'b1; end
                                    6'd1, 6'd2: begin
                                        epc_q <= pc_q; tval_q <= '0; flag_q <= 1'b0;
                                        cause_q <= (op == 6'd1) ? CAUSE_W'(11) : CAUSE_W'(3);
                                        state_q <= EXC_EPC;
                                    end
                                    default: begin pc_q <= pc_next_seq; pc_seq_q <= 1'b1; ic_q <= 1'b1; end
                                endcase
                            end
                            default: begin pc_q <= pc_next_seq; pc_seq_q <= 1'b1; ic_q <= 1'b1; end
                        endcase
                    end
                end
                BRANCH_TAKEN: begin
`ifdef FWRISC_EXEC_MISALIGN_TRAP_EN
                    if (br_misalign) begin
                        epc_q <= pc_q; tval_q <= br_target; flag_q <= 1'b0; cause_q <= '0;
                        state_q <= EXC_EPC;
                    end else
`endif
                    begin pc_q <= br_target; pc_seq_q <= 1'b0; ic_q <= 1'b1; state_q <= EXECUTE; end
                end
                JUMP: begin
`ifdef FWRISC_EXEC_MISALIGN_TRAP_EN
                    if (jmp_misalign) begin
                        epc_q <= pc_q; tval_q <= jmp_target; flag_q <= 1'b0; cause_q <= '0;
                        state_q <= EXC_EPC;
                    end else
`endif
                    begin pc_q <= jmp_target; pc_seq_q <= 1'b0; ic_q <= 1'b1; state_q <= EXECUTE; end
                end
                CSR: begin pc_q <= pc_next_seq; pc_seq_q <= 1'b1; ic_q <= 1'b1; state_q <= EXECUTE; end
                MDS_WAIT: if (mds_out_valid) begin
                    pc_q <= pc_next_seq; pc_seq_q <= 1'b1; ic_q <= 1'b1; state_q <= EXECUTE;
                end
                LDST_WAIT: if (mem_ack_valid) begin
                    mem_req_valid_q <= 1'b0;
                    pc_q <= pc_next_seq; pc_seq_q <= 1'b1; ic_q <= 1'b1; state_q <= EXECUTE;
                end
                EXC_EPC:  state_q <= EXC_TVAL;
                EXC_TVAL: state_q <= EXC_CAUSE;
                EXC_CAUSE: begin pc_q <= trap_target; pc_seq_q <= 1'b0; ic_q <= 1'b1; state_q <= EXECUTE; end
                default: state_q <= EXECUTE;
            endcase
        end
    end

    assign instr_complete = ic_q;
    assign pc             = pc_q;
    assign pc_seq         = pc_seq_q;
    assign mds_in_valid   = mds_in_valid_q;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_addr   = mem_req_addr_q;
endmodule
